multu_ctl: RTL

MULTU_CTL -- requirements
Module: multu_ctl

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mul_shift_add.sv | 31 +++
 rtl/multu_ctl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Definitions shared by the multiply/divide unit blocks:
//   - DEFAULT_WIDTH : default operand width (HI and LO are each this wide)
//   - SEL_HI/SEL_LO : move-from-HI / move-from-LO read select codes
//   - state_t       : sequencer state encoding (IDLE, RUN, DONE)
// ----------------------------------------------------------------------------
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] SEL_HI = 2'b01;
  localparam logic [1:0] SEL_LO = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// ----------------------------------------------------------------------------
// mul_shift_add
// One step of the radix-2 shift-and-add unsigned multiplier (purely
// combinational).
//   i_p : current partial product {upper, lower}, 2*WIDTH bits
//   i_m : multiplicand, WIDTH bits
//   o_p : next partial product, 2*WIDTH bits
// When i_p[0] is set, the multiplicand is added to the upper half. The sum is
// WIDTH+1 bits wide, so the carry is kept. The whole value {carry, upper,
// lower} is then shifted right by one.
// ----------------------------------------------------------------------------
module mul_shift_add #(
  parameter int WIDTH = mdu_pkg::DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_p
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_addend = i_p[0] ? i_m : {WIDTH{1'b0}};
    w_sum    = {1'b0, i_p[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    // The carry becomes the new MSB. Bit 0 of the lower half has been consumed
    // and drops out of the shift.
    o_p      = {w_sum, i_p[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_ctl.sv
// ----------------------------------------------------------------------------
// multu_ctl
// Iterative unsigned multiplier (multu) with architectural HI/LO registers.
// Latency is a fixed WIDTH cycles. There is no early exit.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : multu request from EX (already qualified by a valid instruction)
//   src_a    : multiplicand, sampled when start is accepted
//   src_b    : multiplier, sampled when start is accepted
//   sel      : 01 = mfhi, 10 = mflo, other values = no read
//   hilo_out : HI/LO read data, 0 when no read is selected
//   hi, lo   : architectural HI/LO registers
//   busy     : a multiply is in progress (state RUN)
//   stall    : busy and the pipeline is presenting a multu/mfhi/mflo request
//   done     : one-cycle pulse after HI/LO have just been written
// ----------------------------------------------------------------------------
module multu_ctl
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [2*WIDTH-1:0] w_p_nxt;

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p (r_p),
    .i_m (r_m),
    .o_p (w_p_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // start is ignored here. The stall output makes the pipeline hold
        // the request and present it again later.
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_p    <= '0;
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_p   <= {{WIDTH{1'b0}}, src_b};
        r_m   <= src_a;
        r_cnt <= '0;
      end else if (w_step) begin
        r_p <= w_p_nxt;
        if (w_last) begin
          // HI/LO change only on the final step. An aborted run never
          // touches them.
          r_hi  <= w_p_nxt[2*WIDTH-1:WIDTH];
          r_lo  <= w_p_nxt[WIDTH-1:0];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy  = (r_state == RUN);
    stall = busy && (start || (sel == SEL_HI) || (sel == SEL_LO));
    case (sel)
      SEL_HI:  hilo_out = r_hi;
      SEL_LO:  hilo_out = r_lo;
      default: hilo_out = '0;
    endcase
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule
